piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 116 +++++++++++
 tb/tb_piso_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and limits for the PISO serializer.
// PISO_PARITY_EN (optional) enables the trailing even-parity bit; PARITY is always encoded here.
package piso_pkg;

    localparam int unsigned PISO_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear on accept, count while shifting, flag the last data bit.
// Saturates at WIDTH so it never wraps inside a frame.
module piso_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_W'(WIDTH))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB first, with a one-cycle done pulse per frame.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2 || WIDTH > PISO_MAX_WIDTH) begin : g_bad_width
        $error("piso_serializer: WIDTH out of range");
    end

    piso_state_e      r_state;
    piso_state_e      w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic             r_done;
    logic             w_accept;
    logic             w_frame_end;
    logic             w_terminal;

`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_accept),
        .i_enable   (r_state == SHIFT),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_frame_end  = 1'b0;
        load_ready   = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                serial_out   = r_shift[0];
                serial_valid = 1'b1;
                busy         = 1'b1;
                if (w_terminal) begin
`ifdef PISO_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = IDLE;
                    w_frame_end  = 1'b1;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_out   = r_parity;
                serial_valid = 1'b1;
                busy         = 1'b1;
                w_state_next = IDLE;
                w_frame_end  = 1'b1;
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    // done is registered from the frame-end decision, so it lands on the first IDLE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_frame_end;
            if (w_accept) begin
                r_shift <= load_data;
            end else if (r_state == SHIFT) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^load_data;
        end
    end
`endif

    assign done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=8); honours PISO_PARITY_EN when defined.
// Stimulus pushes expected {cycle, bit/done} items; a forked monitor pops them on each output.
module tb_piso_serializer;

    localparam int unsigned WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } sb_item_t;

    sb_item_t sb[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;

    piso_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_item(input int c, input bit is_done, input bit val);
        sb_item_t it;
        it.cyc     = c;
        it.is_done = is_done;
        it.val     = val;
        sb.push_back(it);
    endfunction

    // Expected bits for a frame whose accept edge makes cyc == a; nbits < WIDTH models an abort.
    function automatic void push_frame(input int a, input logic [WIDTH-1:0] d, input int nbits);
        logic [WIDTH-1:0] w;
        w = d;
        for (int i = 0; i < nbits; i++) push_item(a + i, 1'b0, w[i]);
        if (nbits == int'(WIDTH)) begin
`ifdef PISO_PARITY_EN
            push_item(a + int'(WIDTH), 1'b0, ^w);
`endif
            push_item(a + FRAME, 1'b1, 1'b0);
        end
    endfunction

    task automatic monitor();
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    it = sb.pop_front();
                    check("sb_missed_output_at_cycle", cyc, it.cyc);
                end
                if (serial_valid || done) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_output_done", int'(done), 0);
                    end else begin
                        it = sb.pop_front();
                        check("sb_cycle", cyc, it.cyc);
                        check("sb_kind_done", int'(done), int'(it.is_done));
                        check("sb_kind_valid", int'(serial_valid), int'(!it.is_done));
                        if (!it.is_done) check("sb_serial_bit", int'(serial_out), int'(it.val));
                    end
                end
            end
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns with cyc == accept edge.
    task automatic send(input logic [WIDTH-1:0] d, input int nbits, output int a);
        load_valid = 1'b1;
        load_data  = d;
        check("load_ready_idle", int'(load_ready), 1);
        a = cyc + 1;
        push_frame(a, d, nbits);
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_data  = 8'h5A;
    endtask

    task automatic finish_frame();
        repeat (FRAME) @(posedge clk);
        #1;
        check("done_cycle_ready", int'(load_ready), 1);
        @(posedge clk); #1;
        check("idle_busy", int'(busy), 0);
        check("idle_serial_out", int'(serial_out), 0);
    endtask

    initial begin
        int a;
        int a2;
        fork
            monitor();
        join_none

        #1;
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_serial_valid", int'(serial_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_serial_out", int'(serial_out), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 0xA5: 1,0,1,0,0,1,0,1 then (parity 0) then done
        send(8'hA5, WIDTH, a);
        check("first_bit_busy", int'(busy), 1);
        finish_frame();

        // 0x07: parity 1 when enabled
        send(8'h07, WIDTH, a);
        finish_frame();

        // load_valid pulse with 0x3C mid-frame must be ignored
        send(8'hC3, WIDTH, a);
        for (int k = 0; k < FRAME; k++) begin
            check("midframe_load_ready", int'(load_ready), 0);
            check("midframe_busy", int'(busy), 1);
            load_valid = (k == 2);
            load_data  = 8'h3C;
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        check("post_intrusion_done", int'(done), 1);
        @(posedge clk); #1;

        // reset during bit 3 of 0xFF aborts the frame with no done
        send(8'hFF, 3, a);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_serial_valid", int'(serial_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_load_ready", int'(load_ready), 1);
        check("abort_serial_out", int'(serial_out), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_abort_done", int'(done), 0);
        send(8'h01, WIDTH, a);
        finish_frame();

        // load_valid held high: second accept in the done cycle of the first frame
        load_valid = 1'b1;
        load_data  = 8'h01;
        check("b2b_ready_first", int'(load_ready), 1);
        a  = cyc + 1;
        a2 = a + FRAME + 1;
        push_frame(a, 8'h01, WIDTH);
        push_frame(a2, 8'hFF, WIDTH);
        @(posedge clk); #1;
        load_data = 8'hFF;
        repeat (FRAME) @(posedge clk);
        #1;
        check("b2b_done_cycle_done", int'(done), 1);
        check("b2b_done_cycle_ready", int'(load_ready), 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        check("b2b_second_accept_cycle", cyc, a2);
        check("b2b_second_busy", int'(busy), 1);
        finish_frame();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
